// File: rtl/freq_meter_if.sv
// Result bus of the frequency meter: the window count, its update strobe and the saturation flag.
// Latency: none, this is wiring only.
// Backpressure: none; the consumer must take freq_out when freq_valid pulses.
//
// Signals:
//   freq_out    CNT_W  rising edges counted in the last completed gate window
//   freq_valid  1      one-cycle strobe: freq_out/overflow were updated this cycle
//   overflow    1      the last completed window saturated the edge counter
// Modports: master = the meter (drives the bus), slave = the consumer.
interface freq_meter_if #(
    parameter int unsigned CNT_W = 27
);
    logic [CNT_W-1:0] freq_out;
    logic             freq_valid;
    logic             overflow;

    modport master (
        output freq_out,
        output freq_valid,
        output overflow
    );

    modport slave (
        input freq_out,
        input freq_valid,
        input overflow
    );
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous sig_in over GATE_CYCLES sys_clk cycles and publishes one count per window.
// Latency: 3 sys_clk cycles from sig_in rise to counted edge; first result GATE_CYCLES+1 cycles after reset release.
// Backpressure: none; results are strobed by freq_valid and held until the next window closes.
//
// Ports:
//   sys_clk    system clock, all logic on its rising edge
//   sys_rst_n  asynchronous active-low reset
//   sig_in     measured signal, asynchronous to sys_clk; each level must last >= 2 sys_clk cycles
//   start      (FREQ_METER_SINGLE_SHOT_EN only) level-sampled request to run one gate window
//   res        result bus (freq_meter_if.master): freq_out, freq_valid, overflow
//
// Build option: FREQ_METER_SINGLE_SHOT_EN
//   undefined - IDLE lasts one cycle, then windows run back to back forever.
//   defined   - IDLE waits for start; each window ends in DONE with results held,
//               and start in DONE runs one more window. start is ignored while gating.
//
// With the default parameters (100 MHz sys_clk, 1 s window) freq_out reads directly in Hz.
module freq_meter #(
    parameter int unsigned SYS_CLK_FREQ = 100_000_000, // informative: used to derive GATE_CYCLES
    parameter int unsigned GATE_CYCLES  = 100_000_000, // gate window length in sys_clk cycles, >= 2
    parameter int unsigned GATE_W       = 27,          // gate counter width, must hold GATE_CYCLES-1
    parameter int unsigned CNT_W        = 27           // edge counter / freq_out width
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         sig_in,
`ifdef FREQ_METER_SINGLE_SHOT_EN
    input  logic         start,
`endif
    freq_meter_if.master res
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SYS_CLK_FREQ == 0) begin : g_bad_sys_clk_freq
        $error("freq_meter: SYS_CLK_FREQ must be non-zero");
    end
    if (GATE_CYCLES < 2) begin : g_bad_gate_cycles
        $error("freq_meter: GATE_CYCLES must be >= 2");
    end
    if (GATE_W < 1 || ((GATE_CYCLES - 1) >> GATE_W) != 0) begin : g_bad_gate_w
        $error("freq_meter: GATE_W too narrow for GATE_CYCLES-1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("freq_meter: CNT_W must be >= 1");
    end

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // ST_DONE is only reachable in the single-shot build.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,      state_d;
    logic [2:0]         sync_q,       sync_d;       // [0]=s1, [1]=s2 (synchronized), [2]=s3 (delayed)
    logic [GATE_W-1:0]  gate_cnt_q,   gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q,   edge_cnt_d;
    logic               sat_q,        sat_d;        // edge counter hit all-ones with a further rise
    logic [CNT_W-1:0]   freq_out_q,   freq_out_d;
    logic               freq_valid_q, freq_valid_d;
    logic               overflow_q,   overflow_d;

    // FSM outputs
    logic gate_en;      // counting edges this cycle
    logic win_close;    // last cycle of the current window

    // Datapath helpers
    logic             gate_last;
    logic             rise;
    logic [CNT_W:0]   edge_sum;     // edge_cnt_q + rise with carry out
    logic [CNT_W-1:0] edge_sat;     // edge_sum clamped to all-ones

    // ------------------------------------------------------------------
    // Input synchronizer and edge detect
    // ------------------------------------------------------------------
    // The shift chain is never cleared at window boundaries, so a level that
    // was already high when a window opens does not look like a fresh edge.
    always_comb begin : sync_next
        sync_d = {sync_q[1:0], sig_in};
    end

    assign rise      = sync_q[1] & ~sync_q[2];
    assign gate_last = (gate_cnt_q == GATE_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin : fsm_state_reg
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin : fsm_next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef FREQ_METER_SINGLE_SHOT_EN
                if (start) begin
                    state_d = ST_GATE;
                end
`else
                state_d = ST_GATE;
`endif
            end
            ST_GATE: begin
                if (gate_last) begin
`ifdef FREQ_METER_SINGLE_SHOT_EN
                    state_d = ST_DONE;
`else
                    // Back-to-back windows: no dead cycle between them.
                    state_d = ST_GATE;
`endif
                end
            end
            ST_DONE: begin
`ifdef FREQ_METER_SINGLE_SHOT_EN
                if (start) begin
                    state_d = ST_GATE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin : fsm_outputs
        gate_en   = (state_q == ST_GATE);
        win_close = gate_en && gate_last;
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin : datapath_next
        edge_sum = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, rise};
        edge_sat = edge_sum[CNT_W] ? {CNT_W{1'b1}} : edge_sum[CNT_W-1:0];

        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        sat_d        = sat_q;
        freq_out_d   = freq_out_q;
        overflow_d   = overflow_q;
        freq_valid_d = 1'b0;

        if (win_close) begin
            // A rise seen in the closing cycle still belongs to this window;
            // the counters restart from zero so the next cycle opens a fresh one.
            freq_out_d   = edge_sat;
            overflow_d   = sat_q | edge_sum[CNT_W];
            freq_valid_d = 1'b1;
            gate_cnt_d   = '0;
            edge_cnt_d   = '0;
            sat_d        = 1'b0;
        end else if (gate_en) begin
            gate_cnt_d   = gate_cnt_q + GATE_W'(1);
            edge_cnt_d   = edge_sat;
            sat_d        = sat_q | edge_sum[CNT_W];
        end else begin
            // Idle or done: keep counters parked at zero for the next window.
            gate_cnt_d   = '0;
            edge_cnt_d   = '0;
            sat_d        = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin : datapath_regs
        if (!sys_rst_n) begin
            sync_q       <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_out_q   <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            freq_out_q   <= freq_out_d;
            freq_valid_q <= freq_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Result bus
    // ------------------------------------------------------------------
    assign res.freq_out   = freq_out_q;
    assign res.freq_valid = freq_valid_q;
    assign res.overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (CNT_W=8 and CNT_W=3) share clock, reset and sig_in.
// Latency under test: 3 cycles sig_in->count, first result 101 cycles after reset release.
// Backpressure: none on the DUT; the bench samples results on the falling edge.
module tb_freq_meter;

    localparam int GC = 100;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic sys_rst_n;
    logic sig_in;
`ifdef FREQ_METER_SINGLE_SHOT_EN
    logic start;
`endif

    freq_meter_if #(.CNT_W(8)) r8 ();
    freq_meter_if #(.CNT_W(3)) r3 ();

    freq_meter #(.SYS_CLK_FREQ(100_000_000), .GATE_CYCLES(GC), .GATE_W(7), .CNT_W(8)) u_dut8 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sig_in    (sig_in),
`ifdef FREQ_METER_SINGLE_SHOT_EN
        .start     (start),
`endif
        .res       (r8)
    );

    freq_meter #(.SYS_CLK_FREQ(100_000_000), .GATE_CYCLES(GC), .GATE_W(7), .CNT_W(3)) u_dut3 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sig_in    (sig_in),
`ifdef FREQ_METER_SINGLE_SHOT_EN
        .start     (start),
`endif
        .res       (r3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: every 0->1 of the driven sig_in is logged with the number of
    // the clock edge it was driven after (edges counted from reset release).
    // Such a rise is counted 3 edges later; window k spans counting edges
    // 2+100k .. 101+100k, so it owns rises with (m+1)/100 == k.
    int  cyc;
    int  rises[$];
    bit  model_on;
    int  exp8, exp3;
    bit  eof8, eof3;

    // Observed results
    int  rep8[int];
    int  last8, last3;
    bit  lastof8, lastof3;
    int  n_vld;
    int  last_vld_cyc;
    int  ph;

    typedef struct {
        int lo;     // cycles low per period (0: hold high)
        int hi;     // cycles high per period (0: hold low)
        int ncyc;
        int e8;
        int e3;
        bit of3;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int window_count(input int k);
        int n = 0;
        foreach (rises[i]) if ((rises[i] + 1) / GC == k) n++;
        return n;
    endfunction

    function automatic logic wave(input int lo, input int hi, input int p);
        if (hi == 0) return 1'b0;
        if (lo == 0) return 1'b1;
        return (p % (lo + hi)) >= lo;
    endfunction

    task automatic check_outputs();
        bit ev;
        int n;
        ev = (cyc >= GC + 1) && ((cyc - GC - 1) % GC == 0);
        if (ev) begin
            n    = window_count((cyc - GC - 1) / GC);
            exp8 = (n > 255) ? 255 : n;
            eof8 = (n > 255);
            exp3 = (n > 7) ? 7 : n;
            eof3 = (n > 7);
        end
        chk("valid8", r8.freq_valid, ev);
        chk("valid3", r3.freq_valid, ev);
        chk("freq8", r8.freq_out, exp8);
        chk("ovf8", r8.overflow, eof8);
        chk("freq3", r3.freq_out, exp3);
        chk("ovf3", r3.overflow, eof3);
    endtask

    // One clock: advance past the rising edge, sample on the falling edge, then drive sig_in.
    task automatic step(input logic v);
        @(posedge sys_clk);
        if (sys_rst_n) cyc++;
        @(negedge sys_clk);
        if (sys_rst_n && model_on) check_outputs();
        if (sys_rst_n && r8.freq_valid) begin
            n_vld++;
            last_vld_cyc = cyc;
            last8   = int'(r8.freq_out);
            lastof8 = r8.overflow;
            rep8[(cyc - GC - 1) / GC] = int'(r8.freq_out);
        end
        if (sys_rst_n && r3.freq_valid) begin
            last3   = int'(r3.freq_out);
            lastof3 = r3.overflow;
        end
        if (sys_rst_n && v && !sig_in) rises.push_back(cyc);
        sig_in = v;
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc = 0;
        rises.delete();
        rep8.delete();
        if (sig_in) rises.push_back(0);
        exp8 = 0; exp3 = 0; eof8 = 1'b0; eof3 = 1'b0;
    endtask

    task automatic run_wave(input int lo, input int hi, input int ncyc);
        for (int i = 0; i < ncyc; i++) step(wave(lo, hi, i));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_freq8"}, r8.freq_out, 0);
        chk({tag, "_valid8"}, r8.freq_valid, 0);
        chk({tag, "_ovf8"}, r8.overflow, 0);
        chk({tag, "_freq3"}, r3.freq_out, 0);
        chk({tag, "_valid3"}, r3.freq_valid, 0);
        chk({tag, "_ovf3"}, r3.overflow, 0);
    endtask

`ifdef FREQ_METER_SINGLE_SHOT_EN
    task automatic single_shot_test();
        int c0;
        ph = 0;
        repeat (300) begin step(wave(5, 5, ph)); ph++; end
        chk("ss_no_vld_before_start", n_vld, 0);
        for (int s = 0; s < 2; s++) begin
            n_vld = 0;
            c0 = cyc;
            start = 1'b1;
            step(wave(5, 5, ph)); ph++;
            start = 1'b0;
            repeat (400) begin step(wave(5, 5, ph)); ph++; end
            chk("ss_vld_count", n_vld, 1);
            chk("ss_vld_cycle", last_vld_cyc, c0 + GC + 1);
            chk("ss_freq8", last8, 10);
            chk("ss_ovf8", lastof8, 0);
            chk("ss_freq3", last3, 7);
            chk("ss_ovf3", lastof3, 1);
        end
    endtask
`else
    task automatic continuous_test();
        vec_t tbl[8];
        int   k;
        int   m1, m2;

        // Steady-state counts: periods dividing 100 give an exact count per window.
        tbl[0] = '{lo: 5,  hi: 5,  ncyc: 500, e8: 10, e3: 7, of3: 1'b1};
        tbl[1] = '{lo: 10, hi: 0,  ncyc: 300, e8: 0,  e3: 0, of3: 1'b0};
        tbl[2] = '{lo: 0,  hi: 10, ncyc: 300, e8: 0,  e3: 0, of3: 1'b0};
        tbl[3] = '{lo: 2,  hi: 2,  ncyc: 300, e8: 25, e3: 7, of3: 1'b1};
        tbl[4] = '{lo: 10, hi: 10, ncyc: 300, e8: 5,  e3: 5, of3: 1'b0};
        tbl[5] = '{lo: 25, hi: 25, ncyc: 300, e8: 2,  e3: 2, of3: 1'b0};
        tbl[6] = '{lo: 3,  hi: 2,  ncyc: 300, e8: 20, e3: 7, of3: 1'b1};
        tbl[7] = '{lo: 50, hi: 50, ncyc: 300, e8: 1,  e3: 1, of3: 1'b0};

        foreach (tbl[i]) begin
            run_wave(tbl[i].lo, tbl[i].hi, tbl[i].ncyc);
            chk($sformatf("tbl%0d_freq8", i), last8, tbl[i].e8);
            chk($sformatf("tbl%0d_ovf8", i), lastof8, 0);
            chk($sformatf("tbl%0d_freq3", i), last3, tbl[i].e3);
            chk($sformatf("tbl%0d_ovf3", i), lastof3, tbl[i].of3);
        end

        // Randomized waveforms, checked every cycle by the model.
        for (int s = 0; s < 8; s++) begin
            run_wave(int'($urandom_range(2, 9)), int'($urandom_range(2, 9)),
                     int'($urandom_range(150, 250)));
        end
        for (int s = 0; s < 80; s++) begin
            logic lvl;
            lvl = ~sig_in;
            repeat ($urandom_range(2, 15)) step(lvl);
        end

        // Reset in the middle of a window (gate cycle 50).
        run_wave(5, 5, 300);
        for (int i = 0; i < 2 * GC && ((cyc - 2) % GC) != 50; i++) step(1'b0);
        chk("rst_at_gate50", (cyc - 2) % GC, 50);
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) step(1'b0);
        release_reset();
        for (int i = 0; i < 2 * GC && !r8.freq_valid; i++) step(1'b0);
        chk("first_vld_after_rst", cyc, GC + 1);

        // Rise counted in gate cycle 99 of window k, nothing in k+1, rise in cycle 0 of k+2.
        k  = cyc / GC + 2;
        m1 = 2 + GC * k + (GC - 1) - 3;
        m2 = 2 + GC * (k + 2) - 3;
        while (cyc < m1 - 1) step(1'b0);
        step(1'b1); step(1'b1);
        while (cyc < m2 - 1) step(1'b0);
        step(1'b1); step(1'b1);
        for (int i = 0; i < 3 * GC && cyc < GC * (k + 3) + 2; i++) step(1'b0);
        chk("edge_cycle99", rep8.exists(k) ? rep8[k] : -1, 1);
        chk("edge_between", rep8.exists(k + 1) ? rep8[k + 1] : -1, 0);
        chk("edge_cycle0", rep8.exists(k + 2) ? rep8[k + 2] : -1, 1);
    endtask
`endif

    initial begin
        sys_rst_n = 1'b0;
        sig_in    = 1'b0;
        model_on  = 1'b0;
        cyc       = 0;
        n_vld     = 0;
        ph        = 0;
`ifdef FREQ_METER_SINGLE_SHOT_EN
        start     = 1'b0;
`endif
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        release_reset();
`ifdef FREQ_METER_SINGLE_SHOT_EN
        single_shot_test();
`else
        model_on = 1'b1;
        continuous_test();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
